x3_writeback_unit: RTL and testbench
====================================

X3_WRITEBACK_UNIT -- requirements
Module: x3_writeback_unit

Interface
REQ-001 SHALL have Clk  input  1  rising-edge clock.
REQ-002 SHALL have Reset  input  1  reset; synchronous, active-high, sampled on rising Clk.
REQ-003 SHALL have X3_PCAdd4, X3_DataMemOut, X3_ALUOut, X3_HiLoOut  input  32 each  X3 datapath values.
REQ-004 SHALL have X3_MaddOut  input  64  madd result, bits 63:32 to Hi, bits 31:0 to Lo.
REQ-005 SHALL have X3_WriteRegCarry  input  5  destination register.
REQ-006 SHALL have X3_MemToReg, X3_Jal_Mux, X3_SEL_Madd, X3_HiLo_WB, X3_RegWrite, X3_WriteDataHi, X3_WriteDataLo, X3_minRegWrite  input  1 each  controls.
REQ-007 SHALL have X3_BitsIn  input  2  load width: 00 word, 01 half, 10 byte, 11 word.
REQ-008 SHALL have X3_sad_add_b0_out..b3_out  input  32 each  SAD partial sums.
REQ-009 SHALL have WB_WriteData  output  32  register-file write data.
REQ-010 SHALL have WB_WriteReg  output  5  register-file write address.
REQ-011 SHALL have WB_RegWrite  output  1  register-file write enable.
REQ-012 SHALL have Hi, Lo  output  32 each  architectural HI/LO registers.
REQ-013 SHALL have MinSAD  output  32; MinIndex  output  16; MinValid  output  1  running-minimum SAD tracker state.

Function
REQ-014 Load extract SHALL be: half = sign-extended DataMemOut[15:0]; byte = sign-extended DataMemOut[7:0]; word/11 = DataMemOut.
REQ-015 SadSum SHALL be b0+b1+b2+b3, unsigned, truncated to 32 bits (wrap).
REQ-016 Candidate SHALL be SadSum if MinValid=0 or SadSum < MinSAD (strict unsigned), else MinSAD.
REQ-017 WB_WriteData priority SHALL be: minRegWrite -> Candidate; Jal_Mux -> PCAdd4; HiLo_WB -> HiLoOut; MemToReg -> extracted load; else ALUOut.
REQ-018 WB_WriteReg SHALL be 31 when Jal_Mux=1, else WriteRegCarry.
REQ-019 WB_WriteData/WB_WriteReg/WB_RegWrite SHALL be combinational (zero latency); WB_RegWrite = X3_RegWrite.
REQ-020 On Clk with SEL_Madd=1, {Hi,Lo} SHALL load MaddOut, overriding WriteDataHi/Lo in the same cycle.
REQ-021 Else WriteDataHi=1 SHALL load Hi<=ALUOut and WriteDataLo=1 SHALL load Lo<=ALUOut; both set loads both.
REQ-022 Hi/Lo updates SHALL become visible the cycle after the write edge; no internal bypass.
REQ-023 Internal 16-bit candidate counter SHALL increment on each Clk with minRegWrite=1, wrapping 65535->0.
REQ-024 On minRegWrite=1 with strict new minimum or MinValid=0: MinSAD<=SadSum, MinIndex<=counter (pre-increment), MinValid<=1.
REQ-025 Ties SHALL keep the earlier MinSAD/MinIndex.
REQ-026 minRegWrite=0 SHALL leave tracker state unchanged regardless of SAD inputs.

Reset
REQ-027 Reset=1 SHALL clear Hi, Lo, MinSAD, MinIndex, MinValid, counter to 0 on the next rising Clk.
REQ-028 Reset SHALL dominate all simultaneous madd, HI/LO, and min-tracker updates.
REQ-029 Combinational WB outputs SHALL continue to follow inputs during reset.

Structure
REQ-030 Shared package SHALL hold BitsIn encodings, JAL register constant 31, counter width 16.
REQ-031 Min-SAD tracker (sum, compare, counter, state) SHALL be sub-module sad_min_tracker; HI/LO and WB mux stay in top.

Verification
REQ-032 Madd 0x00000001_FFFFFFFE with SEL_Madd=1 and WriteDataHi=1 -> next cycle Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-033 MemToReg=1, BitsIn=10, DataMemOut=0x12345680 -> WB_WriteData=0xFFFFFF80; BitsIn=01 -> 0x00005680.
REQ-034 Jal_Mux=1, HiLo_WB=1, PCAdd4=0x40 -> WB_WriteData=0x40, WB_WriteReg=31.
REQ-035 minRegWrite sums 50, 30, 30, 70 -> MinSAD=30, MinIndex=1, MinValid=1; WB_WriteData per cycle 50, 30, 30, 30.
REQ-036 Partials 0xFFFFFFFF,2,0,0 -> SadSum=1; Reset asserted mid-sequence -> all tracker/HI/LO outputs 0 next cycle, first later candidate index 0.

Source files
------------

// File: rtl/x3_writeback_unit_pkg.sv
// x3_writeback_unit_pkg: shared load-width encodings, JAL register, tracker counter width, load extract helper
package x3_writeback_unit_pkg;
  localparam logic [1:0] BITS_WORD = 2'b00;
  localparam logic [1:0] BITS_HALF = 2'b01;
  localparam logic [1:0] BITS_BYTE = 2'b10;
  localparam logic [1:0] BITS_WORD_ALT = 2'b11;
  localparam logic [4:0] JAL_REG = 5'd31;
  localparam int CNT_W = 16;
  function automatic logic [31:0] load_extract(input logic [1:0] bits, input logic [31:0] d);
    return bits == BITS_HALF ? {{16{d[15]}}, d[15:0]} :
           bits == BITS_BYTE ? {{24{d[7]}}, d[7:0]} : d;
  endfunction
endpackage

// File: rtl/x3_writeback_unit_sad_min_tracker.sv
// sad_min_tracker: sums four SAD partials and tracks the running minimum with its candidate index
//   Clk, Reset        : clock, sync active-high reset
//   en                : a candidate is presented this cycle (X3_minRegWrite)
//   b0..b3            : SAD partial sums
//   candidate         : new sum if it beats (or there is no) current minimum, else current minimum
//   min_sad/min_index/min_valid : tracker state
module sad_min_tracker
  import x3_writeback_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [31:0]      b0,
  input  logic [31:0]      b1,
  input  logic [31:0]      b2,
  input  logic [31:0]      b3,
  output logic [31:0]      candidate,
  output logic [31:0]      min_sad,
  output logic [CNT_W-1:0] min_index,
  output logic             min_valid
);
  logic [31:0] sad_sum;
  logic [CNT_W-1:0] cnt;
  logic take;
  assign sad_sum = b0 + b1 + b2 + b3;
  // strict compare so ties keep the earlier minimum
  assign take = !min_valid || sad_sum < min_sad;
  assign candidate = take ? sad_sum : min_sad;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      min_sad <= '0;
      min_index <= '0;
      min_valid <= 1'b0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (take) begin
        min_sad <= sad_sum;
        min_index <= cnt;
        min_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/x3_writeback_unit.sv
// x3_writeback_unit: X3 writeback mux, HI/LO registers and min-SAD tracker
//   Clk, Reset              : clock, sync active-high reset
//   X3_* datapath/controls  : values and selects from the X3 stage
//   WB_WriteData/Reg/RegWrite : combinational register-file write port
//   Hi, Lo                  : architectural HI/LO registers
//   MinSAD, MinIndex, MinValid : running-minimum SAD state
module x3_writeback_unit
  import x3_writeback_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      X3_PCAdd4,
  input  logic [31:0]      X3_DataMemOut,
  input  logic [31:0]      X3_ALUOut,
  input  logic [31:0]      X3_HiLoOut,
  input  logic [63:0]      X3_MaddOut,
  input  logic [4:0]       X3_WriteRegCarry,
  input  logic             X3_MemToReg,
  input  logic             X3_Jal_Mux,
  input  logic             X3_SEL_Madd,
  input  logic             X3_HiLo_WB,
  input  logic             X3_RegWrite,
  input  logic             X3_WriteDataHi,
  input  logic             X3_WriteDataLo,
  input  logic             X3_minRegWrite,
  input  logic [1:0]       X3_BitsIn,
  input  logic [31:0]      X3_sad_add_b0_out,
  input  logic [31:0]      X3_sad_add_b1_out,
  input  logic [31:0]      X3_sad_add_b2_out,
  input  logic [31:0]      X3_sad_add_b3_out,
  output logic [31:0]      WB_WriteData,
  output logic [4:0]       WB_WriteReg,
  output logic             WB_RegWrite,
  output logic [31:0]      Hi,
  output logic [31:0]      Lo,
  output logic [31:0]      MinSAD,
  output logic [CNT_W-1:0] MinIndex,
  output logic             MinValid
);
  logic [31:0] candidate;
  sad_min_tracker u_tracker (
    .Clk(Clk),
    .Reset(Reset),
    .en(X3_minRegWrite),
    .b0(X3_sad_add_b0_out),
    .b1(X3_sad_add_b1_out),
    .b2(X3_sad_add_b2_out),
    .b3(X3_sad_add_b3_out),
    .candidate(candidate),
    .min_sad(MinSAD),
    .min_index(MinIndex),
    .min_valid(MinValid)
  );
  always_comb begin
    WB_WriteData = X3_minRegWrite ? candidate :
                   X3_Jal_Mux ? X3_PCAdd4 :
                   X3_HiLo_WB ? X3_HiLoOut :
                   X3_MemToReg ? load_extract(X3_BitsIn, X3_DataMemOut) : X3_ALUOut;
    WB_WriteReg = X3_Jal_Mux ? JAL_REG : X3_WriteRegCarry;
    WB_RegWrite = X3_RegWrite;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (X3_SEL_Madd) begin
      {Hi, Lo} <= X3_MaddOut;
    end else begin
      if (X3_WriteDataHi) Hi <= X3_ALUOut;
      if (X3_WriteDataLo) Lo <= X3_ALUOut;
    end
  end
endmodule

// File: tb/tb_x3_writeback_unit.sv
// tb_x3_writeback_unit: directed self-checking bench for x3_writeback_unit
module tb_x3_writeback_unit;
  logic Clk = 1'b0;
  logic Reset;
  logic [31:0] X3_PCAdd4, X3_DataMemOut, X3_ALUOut, X3_HiLoOut;
  logic [63:0] X3_MaddOut;
  logic [4:0] X3_WriteRegCarry;
  logic X3_MemToReg, X3_Jal_Mux, X3_SEL_Madd, X3_HiLo_WB, X3_RegWrite;
  logic X3_WriteDataHi, X3_WriteDataLo, X3_minRegWrite;
  logic [1:0] X3_BitsIn;
  logic [31:0] b0, b1, b2, b3;
  logic [31:0] WB_WriteData, Hi, Lo, MinSAD;
  logic [4:0] WB_WriteReg;
  logic WB_RegWrite, MinValid;
  logic [15:0] MinIndex;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  x3_writeback_unit dut (
    .Clk(Clk), .Reset(Reset),
    .X3_PCAdd4(X3_PCAdd4), .X3_DataMemOut(X3_DataMemOut), .X3_ALUOut(X3_ALUOut),
    .X3_HiLoOut(X3_HiLoOut), .X3_MaddOut(X3_MaddOut), .X3_WriteRegCarry(X3_WriteRegCarry),
    .X3_MemToReg(X3_MemToReg), .X3_Jal_Mux(X3_Jal_Mux), .X3_SEL_Madd(X3_SEL_Madd),
    .X3_HiLo_WB(X3_HiLo_WB), .X3_RegWrite(X3_RegWrite), .X3_WriteDataHi(X3_WriteDataHi),
    .X3_WriteDataLo(X3_WriteDataLo), .X3_minRegWrite(X3_minRegWrite), .X3_BitsIn(X3_BitsIn),
    .X3_sad_add_b0_out(b0), .X3_sad_add_b1_out(b1), .X3_sad_add_b2_out(b2), .X3_sad_add_b3_out(b3),
    .WB_WriteData(WB_WriteData), .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite),
    .Hi(Hi), .Lo(Lo), .MinSAD(MinSAD), .MinIndex(MinIndex), .MinValid(MinValid)
  );

  task automatic clear_inputs();
    Reset = 0; X3_PCAdd4 = 0; X3_DataMemOut = 0; X3_ALUOut = 0; X3_HiLoOut = 0;
    X3_MaddOut = 0; X3_WriteRegCarry = 0; X3_MemToReg = 0; X3_Jal_Mux = 0;
    X3_SEL_Madd = 0; X3_HiLo_WB = 0; X3_RegWrite = 0; X3_WriteDataHi = 0;
    X3_WriteDataLo = 0; X3_minRegWrite = 0; X3_BitsIn = 0; b0 = 0; b1 = 0; b2 = 0; b3 = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_sad(input logic [31:0] s);
    b0 = s; b1 = 0; b2 = 0; b3 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    X3_SEL_Madd = 1; X3_MaddOut = 64'h1234_5678_9ABC_DEF0;
    X3_minRegWrite = 1; set_sad(32'd5);
    X3_ALUOut = 32'hCAFE_0001;
    step();
    X3_minRegWrite = 0;
    step();
    checks++; if (Hi !== 0 || Lo !== 0) begin errors++; $display("FAIL reset_hilo: got %h_%h expected 0_0", Hi, Lo); end
    checks++; if (MinSAD !== 0 || MinIndex !== 0 || MinValid !== 0) begin errors++; $display("FAIL reset_tracker: got %h %h %b expected 0 0 0", MinSAD, MinIndex, MinValid); end
    #1;
    checks++; if (WB_WriteData !== 32'hCAFE_0001) begin errors++; $display("FAIL reset_wb_follow: got %h expected cafe0001", WB_WriteData); end
    clear_inputs();
    step();
  endtask

  task automatic test_load_extract();
    X3_MemToReg = 1; X3_DataMemOut = 32'h1234_5680; X3_ALUOut = 32'hDEAD_BEEF;
    X3_BitsIn = 2'b10; #1;
    checks++; if (WB_WriteData !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_byte: got %h expected ffffff80", WB_WriteData); end
    X3_BitsIn = 2'b01; #1;
    checks++; if (WB_WriteData !== 32'h0000_5680) begin errors++; $display("FAIL load_half: got %h expected 00005680", WB_WriteData); end
    X3_BitsIn = 2'b00; #1;
    checks++; if (WB_WriteData !== 32'h1234_5680) begin errors++; $display("FAIL load_word: got %h expected 12345680", WB_WriteData); end
    X3_BitsIn = 2'b11; #1;
    checks++; if (WB_WriteData !== 32'h1234_5680) begin errors++; $display("FAIL load_word11: got %h expected 12345680", WB_WriteData); end
    X3_DataMemOut = 32'h0000_8A7F; X3_BitsIn = 2'b10; #1;
    checks++; if (WB_WriteData !== 32'h0000_007F) begin errors++; $display("FAIL load_byte_pos: got %h expected 0000007f", WB_WriteData); end
    X3_BitsIn = 2'b01; #1;
    checks++; if (WB_WriteData !== 32'hFFFF_8A7F) begin errors++; $display("FAIL load_half_neg: got %h expected ffff8a7f", WB_WriteData); end
    clear_inputs();
  endtask

  task automatic test_wb_priority();
    X3_PCAdd4 = 32'h40; X3_HiLoOut = 32'h5555_AAAA; X3_ALUOut = 32'h77; X3_WriteRegCarry = 5'd9;
    X3_DataMemOut = 32'h99; X3_MemToReg = 1; X3_Jal_Mux = 1; X3_HiLo_WB = 1; X3_RegWrite = 1; #1;
    checks++; if (WB_WriteData !== 32'h40 || WB_WriteReg !== 5'd31) begin errors++; $display("FAIL wb_jal: got %h r%0d expected 40 r31", WB_WriteData, WB_WriteReg); end
    checks++; if (WB_RegWrite !== 1'b1) begin errors++; $display("FAIL wb_regwrite1: got %b expected 1", WB_RegWrite); end
    X3_Jal_Mux = 0; X3_RegWrite = 0; #1;
    checks++; if (WB_WriteData !== 32'h5555_AAAA || WB_WriteReg !== 5'd9) begin errors++; $display("FAIL wb_hilo: got %h r%0d expected 5555aaaa r9", WB_WriteData, WB_WriteReg); end
    checks++; if (WB_RegWrite !== 1'b0) begin errors++; $display("FAIL wb_regwrite0: got %b expected 0", WB_RegWrite); end
    X3_HiLo_WB = 0; #1;
    checks++; if (WB_WriteData !== 32'h99) begin errors++; $display("FAIL wb_mem: got %h expected 99", WB_WriteData); end
    X3_MemToReg = 0; #1;
    checks++; if (WB_WriteData !== 32'h77) begin errors++; $display("FAIL wb_alu: got %h expected 77", WB_WriteData); end
    X3_Jal_Mux = 1; X3_minRegWrite = 1; set_sad(32'd12); #1;
    checks++; if (WB_WriteData !== 32'd12 || WB_WriteReg !== 5'd31) begin errors++; $display("FAIL wb_min_over_jal: got %h r%0d expected c r31", WB_WriteData, WB_WriteReg); end
    clear_inputs();
  endtask

  task automatic test_madd();
    X3_SEL_Madd = 1; X3_WriteDataHi = 1; X3_WriteDataLo = 1; X3_ALUOut = 32'hDEAD;
    X3_MaddOut = 64'h0000_0001_FFFF_FFFE; #1;
    checks++; if (Hi !== 0 || Lo !== 0) begin errors++; $display("FAIL madd_no_bypass: got %h_%h expected 0_0", Hi, Lo); end
    step();
    clear_inputs();
    checks++; if (Hi !== 32'h1 || Lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL madd_load: got %h_%h expected 00000001_fffffffe", Hi, Lo); end
  endtask

  task automatic test_hilo_write();
    X3_WriteDataHi = 1; X3_ALUOut = 32'h11; step();
    checks++; if (Hi !== 32'h11 || Lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL hi_only: got %h_%h expected 11_fffffffe", Hi, Lo); end
    X3_WriteDataHi = 0; X3_WriteDataLo = 1; X3_ALUOut = 32'h22; step();
    checks++; if (Hi !== 32'h11 || Lo !== 32'h22) begin errors++; $display("FAIL lo_only: got %h_%h expected 11_22", Hi, Lo); end
    X3_WriteDataHi = 1; X3_ALUOut = 32'h33; step();
    checks++; if (Hi !== 32'h33 || Lo !== 32'h33) begin errors++; $display("FAIL hi_lo_both: got %h_%h expected 33_33", Hi, Lo); end
    X3_WriteDataHi = 0; X3_WriteDataLo = 0; X3_ALUOut = 32'h44; step();
    checks++; if (Hi !== 32'h33 || Lo !== 32'h33) begin errors++; $display("FAIL hi_lo_hold: got %h_%h expected 33_33", Hi, Lo); end
    clear_inputs();
  endtask

  task automatic test_min_tracker();
    logic [31:0] sums [4] = '{32'd50, 32'd30, 32'd30, 32'd70};
    logic [31:0] wb_exp [4] = '{32'd50, 32'd30, 32'd30, 32'd30};
    X3_minRegWrite = 1;
    for (int i = 0; i < 4; i++) begin
      b0 = sums[i] - 32'd3; b1 = 32'd1; b2 = 32'd1; b3 = 32'd1; #1;
      checks++; if (WB_WriteData !== wb_exp[i]) begin errors++; $display("FAIL min_wb_%0d: got %0d expected %0d", i, WB_WriteData, wb_exp[i]); end
      step();
    end
    X3_minRegWrite = 0;
    checks++; if (MinSAD !== 32'd30 || MinIndex !== 16'd1 || MinValid !== 1'b1) begin errors++; $display("FAIL min_state: got %0d idx %0d v%b expected 30 idx 1 v1", MinSAD, MinIndex, MinValid); end
  endtask

  task automatic test_idle();
    set_sad(32'd2); X3_minRegWrite = 0; step(); step();
    checks++; if (MinSAD !== 32'd30 || MinIndex !== 16'd1 || MinValid !== 1'b1) begin errors++; $display("FAIL min_idle: got %0d idx %0d v%b expected 30 idx 1 v1", MinSAD, MinIndex, MinValid); end
    clear_inputs();
  endtask

  task automatic test_wrap_and_reset();
    b0 = 32'hFFFF_FFFF; b1 = 32'd2; b2 = 0; b3 = 0; X3_minRegWrite = 1; #1;
    checks++; if (WB_WriteData !== 32'd1) begin errors++; $display("FAIL sad_wrap: got %h expected 1", WB_WriteData); end
    step();
    checks++; if (MinSAD !== 32'd1 || MinIndex !== 16'd4) begin errors++; $display("FAIL wrap_min: got %0d idx %0d expected 1 idx 4", MinSAD, MinIndex); end
    X3_WriteDataHi = 1; X3_ALUOut = 32'h66; Reset = 1; set_sad(32'd0); step();
    Reset = 0; X3_WriteDataHi = 0; X3_minRegWrite = 0;
    checks++; if (Hi !== 0 || Lo !== 0 || MinSAD !== 0 || MinIndex !== 0 || MinValid !== 0) begin errors++; $display("FAIL mid_reset: got %h %h %h %h %b expected all 0", Hi, Lo, MinSAD, MinIndex, MinValid); end
    X3_minRegWrite = 1; set_sad(32'd9); #1;
    checks++; if (WB_WriteData !== 32'd9) begin errors++; $display("FAIL post_reset_cand: got %0d expected 9", WB_WriteData); end
    step();
    checks++; if (MinSAD !== 32'd9 || MinIndex !== 16'd0 || MinValid !== 1'b1) begin errors++; $display("FAIL post_reset_idx: got %0d idx %0d v%b expected 9 idx 0 v1", MinSAD, MinIndex, MinValid); end
    set_sad(32'd4); step();
    checks++; if (MinSAD !== 32'd4 || MinIndex !== 16'd1) begin errors++; $display("FAIL post_reset_next: got %0d idx %0d expected 4 idx 1", MinSAD, MinIndex); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_load_extract();
    test_wb_priority();
    test_madd();
    test_hilo_write();
    test_min_tracker();
    test_idle();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
